// File: rtl/controle_pkg.sv
// Shared types and constants for the reaction-game round sequencer.
package controle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ESPERA,
        GO,
        RESULTADO,
        FIM
    } estado_t;

    localparam logic [1:0] VENC_NONE = 2'b00;
    localparam logic [1:0] VENC_P1   = 2'b01;
    localparam logic [1:0] VENC_P2   = 2'b10;

    // Fibonacci LFSR, taps 16,14,13,11 map to bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit LFSR; a non-zero seed keeps it out of the all-zero lockup.
module lfsr16
    import controle_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] out
);

    // Advance one step every cycle regardless of the game state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) out <= LFSR_SEED;
        else        out <= lfsr_step(out);
    end

endmodule

// File: rtl/controle_partida.sv
// Round sequencer and button arbiter for the two-player reaction game.
module controle_partida
    import controle_pkg::*;
#(
    parameter int unsigned MIN_DELAY   = 1000,
    parameter logic [15:0] RAND_MASK   = 16'h0FFF,
    parameter int unsigned TIMEOUT     = 5000,
    parameter int unsigned RESULT_HOLD = 2000,
    parameter int unsigned WIN_POINTS  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       btn1,
    input  logic       btn2,
    output logic       p1vic,
    output logic       p2vic,
    output logic       placar_clr,
    output logic       go_led,
    output logic [1:0] falta,
    output logic       fim,
    output logic [1:0] vencedor
);

    localparam logic [3:0]  WIN          = 4'(WIN_POINTS);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] HOLD         = 32'(RESULT_HOLD);

    estado_t     state;
    logic [31:0] cnt;
    logic [3:0]  pontos1;
    logic [3:0]  pontos2;
    logic [15:0] lfsr;
    logic        start_q;
    logic        btn1_q;
    logic        btn2_q;
    logic        start_edge;
    logic        btn1_edge;
    logic        btn2_edge;
    logic [31:0] new_delay;

    lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .out   (lfsr)
    );

    assign start_edge = start & ~start_q;
    assign btn1_edge  = btn1 & ~btn1_q;
    assign btn2_edge  = btn2 & ~btn2_q;
    assign new_delay  = 32'(MIN_DELAY) + {16'b0, lfsr & RAND_MASK};

    // Score increments stop at the winning total
    function automatic logic [3:0] sat_inc(input logic [3:0] p);
        return (p >= WIN) ? WIN : p + 4'd1;
    endfunction

    // Previous-cycle levels for rising-edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
            btn1_q  <= 1'b0;
            btn2_q  <= 1'b0;
        end else begin
            start_q <= start;
            btn1_q  <= btn1;
            btn2_q  <= btn2;
        end
    end

    // Round sequencer: one counter reused for wait delay, GO timeout and result hold
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pontos1    <= '0;
            pontos2    <= '0;
            p1vic      <= 1'b0;
            p2vic      <= 1'b0;
            placar_clr <= 1'b0;
            go_led     <= 1'b0;
            falta      <= 2'b00;
            fim        <= 1'b0;
            vencedor   <= VENC_NONE;
        end else begin
            p1vic      <= 1'b0;
            p2vic      <= 1'b0;
            placar_clr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        state <= ESPERA;
                        cnt   <= new_delay;
                        falta <= 2'b00;
                    end
                end
                ESPERA: begin
                    if (btn1_edge || btn2_edge) begin
                        // a false start hands the point to the opponent
                        falta <= {btn2_edge, btn1_edge};
                        if (btn1_edge && !btn2_edge) begin
                            p2vic   <= 1'b1;
                            pontos2 <= sat_inc(pontos2);
                        end
                        if (btn2_edge && !btn1_edge) begin
                            p1vic   <= 1'b1;
                            pontos1 <= sat_inc(pontos1);
                        end
                        state <= RESULTADO;
                        cnt   <= HOLD;
                    end else if (cnt <= 32'd1) begin
                        state  <= GO;
                        go_led <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                GO: begin
                    if (btn1_edge || btn2_edge) begin
                        if (btn1_edge && !btn2_edge) begin
                            p1vic   <= 1'b1;
                            pontos1 <= sat_inc(pontos1);
                        end
                        if (btn2_edge && !btn1_edge) begin
                            p2vic   <= 1'b1;
                            pontos2 <= sat_inc(pontos2);
                        end
                        go_led <= 1'b0;
                        state  <= RESULTADO;
                        cnt    <= HOLD;
                    end else if (cnt >= TIMEOUT_LAST) begin
                        go_led <= 1'b0;
                        state  <= RESULTADO;
                        cnt    <= HOLD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RESULTADO: begin
                    if (cnt <= 32'd1) begin
                        if (pontos1 == WIN) begin
                            state    <= FIM;
                            fim      <= 1'b1;
                            vencedor <= VENC_P1;
                        end else if (pontos2 == WIN) begin
                            state    <= FIM;
                            fim      <= 1'b1;
                            vencedor <= VENC_P2;
                        end else begin
                            state <= ESPERA;
                            cnt   <= new_delay;
                            falta <= 2'b00;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                FIM: begin
                    if (start_edge) begin
                        placar_clr <= 1'b1;
                        pontos1    <= '0;
                        pontos2    <= '0;
                        vencedor   <= VENC_NONE;
                        fim        <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_partida.sv
// Bench for controle_partida: deadline-based reference model plus directed rounds.
module tb_controle_partida;

    localparam int MD = 10;
    localparam int RM = 15;
    localparam int TO = 50;
    localparam int RH = 5;
    localparam int WP = 3;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_GO   = 2;
    localparam int P_RES  = 3;
    localparam int P_FIM  = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       btn1  = 1'b0;
    logic       btn2  = 1'b0;
    logic       p1vic;
    logic       p2vic;
    logic       placar_clr;
    logic       go_led;
    logic [1:0] falta;
    logic       fim;
    logic [1:0] vencedor;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    controle_partida #(
        .MIN_DELAY   (MD),
        .RAND_MASK   (16'(RM)),
        .TIMEOUT     (TO),
        .RESULT_HOLD (RH),
        .WIN_POINTS  (WP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .btn1       (btn1),
        .btn2       (btn2),
        .p1vic      (p1vic),
        .p2vic      (p2vic),
        .placar_clr (placar_clr),
        .go_led     (go_led),
        .falta      (falta),
        .fim        (fim),
        .vencedor   (vencedor)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int         ph;
    int         dl;
    int         cyc;
    int         pts1;
    int         pts2;
    logic [15:0] lfsr_m;
    logic       s_q, b1_q, b2_q;
    logic       m_p1v, m_p2v, m_clr, m_go, m_fim;
    logic [1:0] m_falta, m_venc;
    logic       e_s, e1, e2;

    assign e_s = start & ~s_q;
    assign e1  = btn1 & ~b1_q;
    assign e2  = btn2 & ~b2_q;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return (s << 1) | 16'(fb);
    endfunction

    function automatic int bump(input int p);
        return (p + 1 > WP) ? WP : p + 1;
    endfunction

    function automatic int rand_delay(input logic [15:0] s);
        return MD + int'(s % 16'(RM + 1));
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph <= P_IDLE; dl <= 0; cyc <= 0; pts1 <= 0; pts2 <= 0;
            lfsr_m <= 16'hACE1; s_q <= 1'b0; b1_q <= 1'b0; b2_q <= 1'b0;
            m_p1v <= 1'b0; m_p2v <= 1'b0; m_clr <= 1'b0; m_go <= 1'b0; m_fim <= 1'b0;
            m_falta <= 2'b00; m_venc <= 2'b00;
        end else begin
            s_q <= start; b1_q <= btn1; b2_q <= btn2;
            lfsr_m <= lfsr_next(lfsr_m);
            cyc <= cyc + 1;
            m_p1v <= 1'b0; m_p2v <= 1'b0; m_clr <= 1'b0;
            case (ph)
                P_IDLE: if (e_s) begin
                    ph <= P_WAIT; dl <= cyc + rand_delay(lfsr_m); m_falta <= 2'b00;
                end
                P_WAIT: if (e1 || e2) begin
                    ph <= P_RES; dl <= cyc + RH; m_falta <= {e2, e1};
                    if (e1 && !e2) begin m_p2v <= 1'b1; pts2 <= bump(pts2); end
                    if (e2 && !e1) begin m_p1v <= 1'b1; pts1 <= bump(pts1); end
                end else if (cyc == dl) begin
                    ph <= P_GO; m_go <= 1'b1; dl <= cyc + TO;
                end
                P_GO: if (e1 || e2 || cyc == dl) begin
                    ph <= P_RES; m_go <= 1'b0; dl <= cyc + RH;
                    if (e1 && !e2) begin m_p1v <= 1'b1; pts1 <= bump(pts1); end
                    if (e2 && !e1) begin m_p2v <= 1'b1; pts2 <= bump(pts2); end
                end
                P_RES: if (cyc == dl) begin
                    if (pts1 == WP) begin ph <= P_FIM; m_fim <= 1'b1; m_venc <= 2'b01; end
                    else if (pts2 == WP) begin ph <= P_FIM; m_fim <= 1'b1; m_venc <= 2'b10; end
                    else begin ph <= P_WAIT; dl <= cyc + rand_delay(lfsr_m); m_falta <= 2'b00; end
                end
                P_FIM: if (e_s) begin
                    m_clr <= 1'b1; pts1 <= 0; pts2 <= 0; m_venc <= 2'b00; m_fim <= 1'b0; ph <= P_IDLE;
                end
                default: ph <= P_IDLE;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en)
            chk("cycle_outputs",
                32'({p1vic, p2vic, placar_clr, go_led, falta, fim, vencedor}),
                32'({m_p1v, m_p2v, m_clr, m_go, m_falta, m_fim, m_venc}));
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input int which, input logic v);
        case (which)
            0: start = v;
            1: btn1  = v;
            2: btn2  = v;
            default: begin btn1 = v; btn2 = v; end
        endcase
    endtask

    // one-cycle press; the DUT samples the edge at the second posedge
    task automatic press(input int which);
        @(posedge clock); #2;
        drive(which, 1'b1);
        @(posedge clock); #2;
        drive(which, 1'b0);
    endtask

    task automatic wait_for_go(input string tag, output int n);
        n = 0;
        while (!go_led && n < 200) begin @(negedge clock); n++; end
        chk({tag, "_go_rises"}, 32'(go_led), 32'd1);
    endtask

    task automatic wait_for_fim(input string tag);
        int n = 0;
        while (!fim && n < 40) begin @(negedge clock); n++; end
        chk({tag, "_fim"}, 32'(fim), 32'd1);
    endtask

    initial begin
        int n;
        logic seen;

        #3 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs_zero",
            32'({p1vic, p2vic, placar_clr, go_led, falta, fim, vencedor}), 32'd0);
        chk_en = 1'b1;
        @(posedge clock); #2 reset = 1'b1;
        repeat (3) @(negedge clock);

        // match 1, round 1: normal round won by player 1
        press(0);
        wait_for_go("r1", n);
        chk("r1_espera_in_range", 32'(n >= MD && n <= MD + RM + 2), 32'd1);
        @(posedge clock); #2 btn1 = 1'b1;
        @(negedge clock);
        chk("r1_no_pulse_before_edge", 32'(p1vic), 32'd0);
        @(posedge clock); #2 btn1 = 1'b0;
        @(negedge clock);
        chk("r1_p1vic_pulse", 32'(p1vic), 32'd1);
        chk("r1_go_drops", 32'(go_led), 32'd0);
        @(negedge clock);
        chk("r1_p1vic_one_cycle", 32'(p1vic), 32'd0);
        press(2);
        @(negedge clock);
        chk("r1_result_ignores_btn", 32'({p1vic, p2vic}), 32'd0);

        // round 2: player 2 false start -> point to player 1
        repeat (4) @(negedge clock);
        press(2);
        @(negedge clock);
        chk("r2_falsestart_p1vic", 32'(p1vic), 32'd1);
        chk("r2_falsestart_no_p2vic", 32'(p2vic), 32'd0);
        chk("r2_falta", 32'(falta), 32'd2);
        chk("r2_no_go", 32'(go_led), 32'd0);

        // round 3: tie in GO
        wait_for_go("r3", n);
        chk("r3_falta_cleared", 32'(falta), 32'd0);
        press(3);
        @(negedge clock);
        chk("r3_tie_no_pulse", 32'({p1vic, p2vic}), 32'd0);
        chk("r3_tie_ends_go", 32'(go_led), 32'd0);

        // round 4: timeout
        wait_for_go("r4", n);
        n = 0; seen = 1'b0;
        while (go_led && n < 100) begin
            seen = seen | p1vic | p2vic;
            @(negedge clock); n++;
        end
        chk("r4_timeout_len", 32'(n), 32'(TO));
        chk("r4_timeout_no_pulse", 32'(seen | p1vic | p2vic), 32'd0);

        // round 5: btn1 held from RESULTADO into GO, then re-pressed
        @(posedge clock); #2 btn1 = 1'b1;
        wait_for_go("r5", n);
        seen = 1'b0;
        repeat (3) begin @(negedge clock); seen = seen | p1vic | p2vic; end
        chk("r5_held_no_point", 32'(seen), 32'd0);
        chk("r5_held_no_falsestart", 32'(falta), 32'd0);
        chk("r5_still_go", 32'(go_led), 32'd1);
        @(posedge clock); #2 btn1 = 1'b0;
        press(1);
        @(negedge clock);
        chk("r5_repress_p1vic", 32'(p1vic), 32'd1);
        wait_for_fim("m1");
        chk("m1_vencedor_p1", 32'(vencedor), 32'd1);
        press(1);
        @(negedge clock);
        chk("m1_fim_no_pulse_btn1", 32'({p1vic, p2vic}), 32'd0);
        press(0);
        @(negedge clock);
        chk("m1_placar_clr", 32'(placar_clr), 32'd1);
        chk("m1_fim_cleared", 32'(fim), 32'd0);
        chk("m1_vencedor_cleared", 32'(vencedor), 32'd0);
        @(negedge clock);
        chk("m1_placar_clr_one_cycle", 32'(placar_clr), 32'd0);

        // match 2: player 2 takes three rounds
        press(0);
        wait_for_go("m2r1", n);
        press(0);
        @(negedge clock);
        chk("m2r1_start_ignored_in_go", 32'(go_led), 32'd1);
        press(2);
        @(negedge clock);
        chk("m2r1_p2vic", 32'(p2vic), 32'd1);
        repeat (4) @(negedge clock);
        press(1);
        @(negedge clock);
        chk("m2r2_falsestart_p2vic", 32'(p2vic), 32'd1);
        chk("m2r2_falta", 32'(falta), 32'd1);
        wait_for_go("m2r3", n);
        press(2);
        @(negedge clock);
        chk("m2r3_p2vic", 32'(p2vic), 32'd1);
        wait_for_fim("m2");
        chk("m2_vencedor_p2", 32'(vencedor), 32'd2);
        press(1);
        @(negedge clock);
        chk("m2_fim_no_pulse_btn1", 32'({p1vic, p2vic}), 32'd0);
        press(2);
        @(negedge clock);
        chk("m2_fim_no_pulse_btn2", 32'({p1vic, p2vic}), 32'd0);
        press(0);
        @(negedge clock);
        chk("m2_placar_clr", 32'(placar_clr), 32'd1);
        chk("m2_fim_cleared", 32'(fim), 32'd0);
        chk("m2_vencedor_cleared", 32'(vencedor), 32'd0);

        // asynchronous reset in the middle of GO
        press(0);
        wait_for_go("rst", n);
        @(posedge clock); #3 reset = 1'b0;
        #1;
        chk("async_reset_go_led", 32'(go_led), 32'd0);
        chk("async_reset_outputs",
            32'({p1vic, p2vic, placar_clr, go_led, falta, fim, vencedor}), 32'd0);
        repeat (2) @(negedge clock);
        @(posedge clock); #2 reset = 1'b1;
        repeat (3) @(negedge clock);
        press(1);
        @(negedge clock);
        chk("post_reset_no_stray_pulse", 32'({p1vic, p2vic}), 32'd0);
        repeat (30) @(negedge clock);
        chk("post_reset_idle_no_go", 32'(go_led), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/controle_partida.md
Name: controle_partida

Overview:
- Round sequencer and button arbiter for the two-player reaction game.
- Each round: random wait, then "go" lamp; first player to press after go wins the round.
- Arbitrates p1/p2 buttons, issues one-cycle p1vic/p2vic pulses to the LED scoreboard, ends the match when a player reaches WIN_POINTS.
- Sits between the synchronized button inputs and the scoreboard/LED logic.

Parameters:
- MIN_DELAY, 1000, minimum ESPERA length in cycles (must be >= 1)
- RAND_MASK, 16'h0FFF, mask ANDed with LFSR to form the random extra delay
- TIMEOUT, 5000, GO cycles with no press before the round is void
- RESULT_HOLD, 2000, cycles spent in RESULTADO
- WIN_POINTS, 8, points that end the match (1..8)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  synchronized start button, level
- btn1  in  1  player 1 button, synchronized level
- btn2  in  1  player 2 button, synchronized level
- p1vic  out  1  one-cycle pulse: point to player 1
- p2vic  out  1  one-cycle pulse: point to player 2
- placar_clr  out  1  one-cycle pulse: clear scoreboard (new match)
- go_led  out  1  high only in GO
- falta  out  2  false-start flags of last round {p2,p1}; held until next ESPERA
- fim  out  1  high in FIM
- vencedor  out  2  00 none, 01 p1, 10 p2; valid when fim=1

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0, counters 0, pontos1/pontos2 = 0, LFSR = 16'hACE1.
- Edge detection: rising edge = level now 1, registered level 0; edge registers reset to 0. Only edges act; held buttons never re-trigger.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state, never zero.
- IDLE: start edge -> ESPERA. delay = MIN_DELAY + (lfsr & RAND_MASK), latched on entry; falta cleared.
- ESPERA: counts down delay; go_led=0.
  - btn1 edge only: falta=01, p2vic pulse, -> RESULTADO.
  - btn2 edge only: falta=10, p1vic pulse, -> RESULTADO.
  - Both in the same cycle: falta=11, no point, -> RESULTADO.
  - Count reaches 0 with no edge -> GO.
- GO: go_led=1; timeout counter from 0.
  - btn1 edge only: p1vic.
  - btn2 edge only: p2vic.
  - Both in the same cycle: tie, no point.
  - Any of these -> RESULTADO.
  - TIMEOUT cycles with no edge -> RESULTADO, no point.
- Pulse timing: p1vic/p2vic are registered, high exactly the cycle after the deciding edge, and at most one per round.
- Point counting: pontos1/pontos2 (4 bits, saturating at WIN_POINTS) increment with the pulse.
- RESULTADO: holds RESULT_HOLD cycles, ignores buttons and start.
  - Then if pontos1==WIN_POINTS: FIM, vencedor=01.
  - Else if pontos2==WIN_POINTS: FIM, vencedor=10.
  - Else: ESPERA with a new delay latched.
- FIM: fim=1, no further pulses.
  - start edge: placar_clr pulse, pontos cleared, vencedor=00, -> IDLE.
- start edges outside IDLE/FIM are ignored.
- Reset mid-round: immediate return to IDLE, any pending pulse dropped.
- Counters are 32-bit; all comparisons are unsigned.

Decomposition:
- Package controle_pkg holds:
  - state enum: IDLE, ESPERA, GO, RESULTADO, FIM
  - vencedor encodings
  - LFSR seed and tap constants
- Sub-module lfsr16 (free-running, clock/reset/out[15:0]) is natural and reusable.
- Edge detectors stay inline.

Test Plan:
Bench parameters: MIN_DELAY=10, RAND_MASK=15, TIMEOUT=50, RESULT_HOLD=5, WIN_POINTS=3.
- Normal round: start edge, wait for go_led=1, btn1 edge -> p1vic high exactly 1 cycle, the cycle after the edge; go_led drops; after 5 cycles ESPERA again.
- False start: btn2 edge during ESPERA -> falta=10, p1vic one pulse, no p2vic, go_led never rises that round.
- Tie and timeout:
  - btn1 and btn2 edges in the same GO cycle -> no pulse, round replays.
  - No press for 50 GO cycles -> no pulse, back to ESPERA.
- Match end: player 2 wins 3 rounds -> fim=1, vencedor=10; further button presses give no pulses; start edge -> placar_clr 1 cycle, fim=0, vencedor=00, IDLE.
- Held button: btn1 held high across ESPERA->GO -> no false start, no point until released and pressed again.
- Async reset: assert reset=0 in GO mid-round -> outputs 0 immediately without a clock edge; after release, IDLE and no stray pulse.
